// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths,
// 5-bit opcode constants, and the fetch state enum.
package ifetch_queue_pkg;

  localparam int IFQ_IW    = 9;
  localparam int IFQ_AW    = 8;
  localparam int IFQ_DEPTH = 4;
  localparam int OP_W      = 5;

  localparam logic [OP_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OP_W-1:0] OP_LOAD = 5'h01;
  localparam logic [OP_W-1:0] OP_ADD  = 5'h03;
  localparam logic [OP_W-1:0] OP_JMP  = 5'h05;
  localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} ifq_state_t;

  function automatic logic is_halt(input logic [OP_W-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO with push/pop/clear, occupancy count and
// empty/full flags. Control state resets asynchronously; storage does not.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int W     = IFQ_IW + IFQ_AW,
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy update; clear wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a cleared cycle never writes.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues ROM reads at PC, queues {inst, pc tag},
// hands them to decode on valid/ready, stalls the pc block, honours flush
// and stops fetching after a HALT opcode.
// Build option: define IFQ_BYPASS_EN to present a response arriving at an
// empty queue to decode in the same cycle.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int IW    = IFQ_IW,
  parameter int AW    = IFQ_AW,
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] PC,
  output logic          pc_stall,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic          halted
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = IW + AW;
  localparam logic [CW:0] CREDITS = CW1'(DEPTH);

  ifq_state_t    state_q, state_d;
  logic          inflight_q, inflight_d;
  logic          halt_seen_q, halt_seen_d;
  logic          halted_q, halted_d;
  logic [AW-1:0] tag_q, tag_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic [EW-1:0] fifo_dout;
  logic          fifo_push, fifo_pop;
  logic          resp_vld, halt_hit;
  logic [CW:0]   credit_used;

  // Response acceptance and the issue rule; a HALT arriving this cycle
  // already blocks the next request so nothing past it is fetched.
  always_comb begin
    resp_vld    = inflight_q && !flush;
    halt_hit    = resp_vld && is_halt(imem_data[IW-1 -: OP_W]);
    credit_used = {1'b0, fifo_count} + CW1'(inflight_q);
    imem_req    = (state_q == RUN) && !flush && (credit_used < CREDITS) &&
                  !fifo_full && !halt_seen_q && !halt_hit;
    pc_stall    = !imem_req;
    imem_addr   = PC;
    inflight_d  = imem_req;
    tag_d       = imem_req ? PC : tag_q;
  end

`ifdef IFQ_BYPASS_EN
  logic bypass;

  // Decode-side mux: an empty queue forwards the arriving response directly.
  always_comb begin
    bypass     = fifo_empty && resp_vld;
    inst_valid = !fifo_empty || resp_vld;
    if (bypass)           {inst, inst_pc} = {imem_data, tag_q};
    else if (!fifo_empty) {inst, inst_pc} = fifo_dout;
    else                  {inst, inst_pc} = '0;
    fifo_push = resp_vld && !(bypass && inst_ready);
    fifo_pop  = !fifo_empty && inst_ready && !flush;
  end
`else
  // Decode-side mux: every response is written first and presented from the head.
  always_comb begin
    inst_valid = !fifo_empty;
    if (!fifo_empty) {inst, inst_pc} = fifo_dout;
    else             {inst, inst_pc} = '0;
    fifo_push = resp_vld;
    fifo_pop  = !fifo_empty && inst_ready && !flush;
  end
`endif

  // Next-state logic: HALT tracking and the IDLE/RUN/HALTED transitions.
  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    case (state_q)
      IDLE:   if (start) state_d = RUN;
      RUN: begin
        if (flush) begin
          halt_seen_d = 1'b0;
        end else if (halt_hit) begin
          halt_seen_d = 1'b1;
        end else if (halt_seen_q && fifo_empty && !inflight_q) begin
          state_d     = HALTED;
          halt_seen_d = 1'b0;
        end
      end
      HALTED: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
    halted_d = (state_d == HALTED);
  end

  // State machine and control registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      inflight_q  <= 1'b0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end

  // PC tag captured alongside each request.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign halted = halted_q;

  ifq_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clear (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({imem_data, tag_q}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: ROM and pc-block responders, a queue-based
// reference model compared every cycle, and directed scenarios with
// hand-computed expectations.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic       clk, reset, start, flush, inst_ready;
  logic [7:0] PC;
  logic       pc_stall, imem_req, inst_valid, halted;
  logic [7:0] imem_addr, inst_pc;
  logic [8:0] imem_data, inst;
  logic       pc_set;
  logic [7:0] pc_set_val;
  logic [8:0] rom [256];

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic [8:0] i; logic [7:0] p;} ent_t;
  ent_t       m_q [$];
  int         m_mode;      // 0 idle, 1 run, 2 halted
  bit         m_pend, m_halt;
  logic [7:0] m_pend_pc;
  logic [7:0] acc_pc [$];
  logic [8:0] acc_inst [$];
  logic [7:0] req_log [$];

  ifetch_queue dut (
    .clk(clk), .reset(reset), .start(start), .PC(PC), .pc_stall(pc_stall),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with one-cycle read latency
  always @(posedge clk) if (imem_req) imem_data <= rom[imem_addr];

  // pc block: load on branch/set, otherwise advance unless stalled
  always @(posedge clk) begin
    if (pc_set) PC <= pc_set_val;
    else if (!pc_stall) PC <= PC + 8'd1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model and per-cycle comparison (inputs are stable at negedge)
  initial begin
    bit resp, rhalt, e_req, byp, e_val, acc, drained, old_halt;
    ent_t e_ent;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_q.delete(); m_mode = 0; m_pend = 0; m_halt = 0;
        check("rst_out", {28'd0, inst_valid, imem_req, pc_stall, halted}, 32'h2);
        continue;
      end
      resp  = m_pend && !flush;
      rhalt = resp && (imem_data[8:4] == 5'h1F);
      e_req = (m_mode == 1) && !flush && (m_q.size() + int'(m_pend)) < 4 && !m_halt && !rhalt;
      byp   = BYP && (m_q.size() == 0) && resp;
      e_val = (m_q.size() > 0) || byp;
      e_ent = (m_q.size() > 0) ? m_q[0] : ent_t'({imem_data, m_pend_pc});
      check("req", {31'd0, imem_req}, {31'd0, e_req});
      check("stall", {31'd0, pc_stall}, {31'd0, !e_req});
      check("valid", {31'd0, inst_valid}, {31'd0, e_val});
      check("halted", {31'd0, halted}, {31'd0, m_mode == 2});
      if (e_req) check("addr", {24'd0, imem_addr}, {24'd0, PC});
      if (e_val) check("head", {15'd0, inst, inst_pc}, {15'd0, e_ent});
      if (imem_req) req_log.push_back(imem_addr);
      acc = inst_valid && inst_ready && !flush;
      if (acc) begin acc_pc.push_back(inst_pc); acc_inst.push_back(inst); end
      // advance the model
      drained  = (m_q.size() == 0) && !m_pend;
      old_halt = m_halt;
      if (flush) begin
        m_q.delete();
        m_halt = 0;
      end else begin
        if (e_val && inst_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (resp && !(byp && inst_ready)) m_q.push_back({imem_data, m_pend_pc});
        if (rhalt) m_halt = 1;
      end
      if (m_mode != 1) begin
        if (start) m_mode = 1;
      end else if (old_halt && drained && !flush) begin
        m_mode = 2; m_halt = 0;
      end
      m_pend = e_req;
      if (e_req) m_pend_pc = PC;
    end
  end

  task automatic do_reset(input logic [7:0] pcv);
    reset = 1; start = 0; flush = 0; pc_set = 1; pc_set_val = pcv;
    step(); step();
    reset = 0; pc_set = 0;
    acc_pc.delete(); acc_inst.delete(); req_log.delete();
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  initial begin
    int first_req, first_val, reqs, n6;
    for (int a = 0; a < 256; a++) rom[a] = 9'(a);
    reset = 1; start = 0; flush = 0; inst_ready = 0; pc_set = 1; pc_set_val = 0;
    step(); step();
    // reset values
    check("rst_valid", {31'd0, inst_valid}, 0);
    check("rst_req", {31'd0, imem_req}, 0);
    check("rst_stall", {31'd0, pc_stall}, 1);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_inst", {15'd0, inst, inst_pc}, 0);

    // streaming with ready held high
    do_reset(8'd0);
    inst_ready = 1;
    pulse_start();
    first_req = -1; first_val = -1; reqs = 0;
    for (int k = 0; k < 12; k++) begin
      if (imem_req) reqs++;
      if (imem_req && first_req < 0) first_req = k;
      if (inst_valid && first_val < 0) first_val = k;
      step();
    end
    check("t1_first_req", first_req, 0);
    check("t1_latency", first_val - first_req, LAT);
    check("t1_req_every_cycle", reqs, 12);
    check("t1_nacc", {31'd0, acc_pc.size() >= 6}, 1);
    for (int i = 0; i < 6; i++)
      if (i < acc_pc.size()) check("t1_seq", {15'd0, acc_inst[i], acc_pc[i]}, {15'd0, 9'(i), 8'(i)});

    // back-pressure from the decoder
    do_reset(8'd0);
    inst_ready = 0;
    pulse_start();
    repeat (8) step();
    check("t2_nreq", req_log.size(), 4);
    if (req_log.size() == 4)
      check("t2_reqs", {req_log[0], req_log[1], req_log[2], req_log[3]}, 32'h00010203);
    check("t2_stall", {31'd0, pc_stall}, 1);
    check("t2_pc", {24'd0, PC}, 4);
    check("t2_head", {15'd0, inst, inst_pc}, {15'd0, 9'd0, 8'd0});
    inst_ready = 1; step(); inst_ready = 0;
    repeat (4) step();
    check("t2_pop", {24'd0, acc_pc.size() == 1 ? acc_pc[0] : 8'hFF}, 0);
    check("t2_one_more", {24'd0, req_log.size() == 5 ? req_log[4] : 8'hFF}, 4);
    check("t2_pc2", {24'd0, PC}, 5);

    // flush with PC 6 in flight and tags 4,5 queued
    do_reset(8'd4);
    inst_ready = 0;
    pulse_start();
    repeat (3) step();
    check("t3_pre", {8'd0, req_log.size() == 3 ? {req_log[0], req_log[1], req_log[2]} : 24'hFFFFFF}, 32'h040506);
    flush = 1; pc_set = 1; pc_set_val = 8'd25;
    #1 check("t3_flush_req", {31'd0, imem_req}, 0);
    step();
    flush = 0; pc_set = 0;
    check("t3_valid_after", {31'd0, inst_valid}, 0);
    req_log.delete();
    inst_ready = 1;
    repeat (6) step();
    check("t3_first_req", {24'd0, req_log.size() > 0 ? req_log[0] : 8'hFF}, 25);
    check("t3_first_acc", {24'd0, acc_pc.size() > 0 ? acc_pc[0] : 8'hFF}, 25);
    n6 = 0;
    foreach (acc_pc[i]) if (acc_pc[i] == 8'd6) n6++;
    check("t3_no_tag6", n6, 0);

    // HALT at address 10
    rom[10] = 9'h1F0;
    do_reset(8'd0);
    inst_ready = 1;
    pulse_start();
    repeat (20) step();
    check("t4_nreq", req_log.size(), 11);
    check("t4_last", {24'd0, req_log.size() > 0 ? req_log[req_log.size()-1] : 8'hFF}, 10);
    check("t4_halted", {31'd0, halted}, 1);
    check("t4_pc", {24'd0, PC}, 11);
    req_log.delete();
    pulse_start();
    repeat (3) step();
    check("t4_resume", {24'd0, req_log.size() > 0 ? req_log[0] : 8'hFF}, 11);
    check("t4_unhalt", {31'd0, halted}, 0);
    rom[10] = 9'd10;

    // asynchronous reset with three entries queued
    do_reset(8'd0);
    inst_ready = 0;
    pulse_start();
    repeat (4) step();
    check("t5_pre_valid", {31'd0, inst_valid}, 1);
    #2 reset = 1;
    #1;
    check("t5_async_valid", {31'd0, inst_valid}, 0);
    check("t5_async_req", {31'd0, imem_req}, 0);
    step(); step();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      check("t5_idle_req", {31'd0, imem_req}, 0);
      step();
    end
    pulse_start();
    check("t5_resume_req", {31'd0, imem_req}, 1);
    check("t5_resume_addr", {24'd0, imem_addr}, 4);

    // HALT fetched, then flushed before it drains
    rom[10] = 9'h1F0;
    do_reset(8'd8);
    inst_ready = 0;
    pulse_start();
    repeat (4) step();
    check("t6_blocked", {31'd0, imem_req}, 0);
    flush = 1; pc_set = 1; pc_set_val = 8'd40;
    step();
    flush = 0; pc_set = 0;
    req_log.delete();
    inst_ready = 1;
    repeat (10) step();
    check("t6_halted", {31'd0, halted}, 0);
    check("t6_target", {24'd0, req_log.size() > 0 ? req_log[0] : 8'hFF}, 40);
    check("t6_continue", {31'd0, req_log.size() >= 8}, 1);
    rom[10] = 9'd10;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
